// File: rtl/udma_cfg_apb_bridge.sv
// APB slave to uDMA configuration-bus initiator: one cfg transfer per APB access.
// Optional REQ-state timeout is enabled by defining CFG_TIMEOUT_EN.
module udma_cfg_apb_bridge #(
  parameter int APB_AWIDTH     = 12,
  parameter int N_PERIPHS      = 4,
  parameter int PERIPH_ID_LSB  = 7,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [APB_AWIDTH-1:0]   paddr_i,
  input  logic [31:0]             pwdata_i,
  input  logic                    pwrite_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  output logic [31:0]             prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [31:0]             cfg_data_o,
  output logic [4:0]              cfg_addr_o,
  output logic [N_PERIPHS-1:0]    cfg_valid_o,
  output logic                    cfg_rwn_o,
  input  logic [N_PERIPHS*32-1:0] cfg_data_i,
  input  logic [N_PERIPHS-1:0]    cfg_ready_i
);

  localparam int PW  = (N_PERIPHS > 1) ? $clog2(N_PERIPHS) : 1;
  localparam int IDW = APB_AWIDTH - PERIPH_ID_LSB;

  typedef enum logic [1:0] {IDLE, REQ, RESP, ERR} state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          id_q, id_d;
  logic [31:0]            prdata_q, prdata_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;
  logic [31:0]            cfg_data_q, cfg_data_d;
  logic [4:0]             cfg_addr_q, cfg_addr_d;
  logic [N_PERIPHS-1:0]   cfg_valid_q, cfg_valid_d;
  logic                   cfg_rwn_q, cfg_rwn_d;

  // The full upper address field is range-checked so addresses beyond the
  // last peripheral fail rather than aliasing onto a real one.
  logic [IDW-1:0] id_field;
  logic [PW-1:0]  id_sel;
  logic           id_bad;
  logic           handshake;
  logic [31:0]    rdata_sel;
  logic           unused_addr;

  assign id_field    = paddr_i[APB_AWIDTH-1:PERIPH_ID_LSB];
  assign id_sel      = paddr_i[PERIPH_ID_LSB +: PW];
  assign id_bad      = 32'(id_field) >= 32'(N_PERIPHS);
  assign handshake   = cfg_valid_q[id_q] & cfg_ready_i[id_q];
  assign rdata_sel   = cfg_data_i[{id_q, 5'd0} +: 32];
  assign unused_addr = ^paddr_i[1:0];

`ifdef CFG_TIMEOUT_EN
  logic [7:0] tmo_cnt_q, tmo_cnt_d;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    cfg_valid_d = cfg_valid_q;
    cfg_addr_d  = cfg_addr_q;
    cfg_rwn_d   = cfg_rwn_q;
    cfg_data_d  = cfg_data_q;
    prdata_d    = '0;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
`ifdef CFG_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (psel_i && !penable_i) begin
          if (id_bad) begin
            state_d   = ERR;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else begin
            state_d             = REQ;
            id_d                = id_sel;
            cfg_addr_d          = paddr_i[6:2];
            cfg_rwn_d           = !pwrite_i;
            cfg_data_d          = pwrite_i ? pwdata_i : 32'd0;
            cfg_valid_d         = '0;
            cfg_valid_d[id_sel] = 1'b1;
`ifdef CFG_TIMEOUT_EN
            tmo_cnt_d           = 8'd0;
`endif
          end
        end
      end
      REQ: begin
        // Valid drops on the accepting edge: reads may clear slave state.
        if (handshake) begin
          state_d     = RESP;
          cfg_valid_d = '0;
          prdata_d    = cfg_rwn_q ? rdata_sel : 32'd0;
          pready_d    = 1'b1;
        end
`ifdef CFG_TIMEOUT_EN
        else if (tmo_cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d     = ERR;
          cfg_valid_d = '0;
          pready_d    = 1'b1;
          pslverr_d   = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      id_q        <= '0;
      prdata_q    <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      cfg_data_q  <= '0;
      cfg_addr_q  <= '0;
      cfg_valid_q <= '0;
      cfg_rwn_q   <= 1'b0;
`ifdef CFG_TIMEOUT_EN
      tmo_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      prdata_q    <= prdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      cfg_data_q  <= cfg_data_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_valid_q <= cfg_valid_d;
      cfg_rwn_q   <= cfg_rwn_d;
`ifdef CFG_TIMEOUT_EN
      tmo_cnt_q   <= tmo_cnt_d;
`endif
    end
  end

  assign prdata_o    = prdata_q;
  assign pready_o    = pready_q;
  assign pslverr_o   = pslverr_q;
  assign cfg_data_o  = cfg_data_q;
  assign cfg_addr_o  = cfg_addr_q;
  assign cfg_valid_o = cfg_valid_q;
  assign cfg_rwn_o   = cfg_rwn_q;

endmodule
